seq_chk: RTL
============

SEQ_CHK -- requirements
Module: seq_chk

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the run-length counter width (max run 2^CNT_W-1 = 255).
REQ-002 SHALL have parameter ERR_W, default 16, meaning the error-counter width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_vld, input, 1, i_seq sampled only when high.
REQ-006 SHALL have port i_seq, input, 1, serial bit from the sequence generator.
REQ-007 SHALL have port i_clr, input, 1, synchronous clear of o_err_cnt.
REQ-008 SHALL have port o_lock, output, 1, high while in LOCK.
REQ-009 SHALL have port o_err, output, 1, one-cycle pulse per detected pattern violation.
REQ-010 SHALL have port o_run_vld, output, 1, one-cycle pulse when a ones-run completes.
REQ-011 SHALL have port o_run_len, output, CNT_W, length of the last completed run, held between pulses.
REQ-012 SHALL have port o_err_cnt, output, ERR_W, saturating count of o_err pulses.

Function
REQ-013 SHALL check the expected stream: single 0 separators between runs of 1s whose lengths increase by 1 per run (1,2,3,...,255), with 1 expected after 255.
REQ-014 SHALL hold all state when i_vld=0; only a sample is a bit event.
REQ-015 SHALL count consecutive 1s in run_cnt; a 0 following a run of L>=1 ends the run: o_run_vld=1 and o_run_len=L in the next cycle.
REQ-016 SHALL treat two consecutive 0s as a run of length 0: o_run_vld=1 and o_run_len=0.
REQ-017 SHALL implement FSM states HUNT, SYNC, LOCK; reset state HUNT.
REQ-018 HUNT: after the first 0, measure the next completed run L; if L>=1, load ref=L and go to SYNC, else stay in HUNT.
REQ-019 SYNC: on run completion, if run==next(ref) go to LOCK with exp=next(next(ref)), else set ref=run and stay in SYNC (or go to HUNT if run==0); no o_err in HUNT or SYNC.
REQ-020 next(x) SHALL be x+1 for x<255 and 1 for x=255.
REQ-021 LOCK: a 1 sampled while run_cnt==exp (too long) or a 0 sampled while 0<run_cnt<exp or run_cnt==0 (too short) SHALL be a violation.
REQ-022 On a violation o_err SHALL be high in the cycle after the offending sample; FSM goes to HUNT (too long) or SYNC with ref=observed run (too short, run>=1).
REQ-023 In LOCK, on a correct run completion exp SHALL advance to next(exp) and o_lock SHALL stay high.
REQ-024 A run reaching 255 with another 1 sampled SHALL saturate run_cnt, discard that run and force HUNT (plus o_err if in LOCK).
REQ-025 o_err_cnt SHALL increment on each o_err and saturate at 2^ERR_W-1; i_clr SHALL clear it, and i_clr with a simultaneous o_err SHALL leave it at 1.
REQ-026 o_lock SHALL drop in the same cycle o_err rises.

Reset
REQ-027 i_reset SHALL immediately force state=HUNT, run_cnt=0, ref=exp=0, o_lock=0, o_err=0, o_run_vld=0, o_run_len=0, o_err_cnt=0, including mid-run.
REQ-028 After reset release, the first sampled bit SHALL be treated as if preceded by no separator (HUNT waits for a 0).

Structure
REQ-029 Package seq_pkg SHALL hold the state encoding (HUNT/SYNC/LOCK), CNT_W and ERR_W defaults, and the next() wrap constant 255.
REQ-030 Run measurement (run_cnt, run-end detect, o_run_vld/o_run_len) SHALL be a sub-module seq_run_meas; FSM and error counter live in seq_chk.

Verification
REQ-031 Clean stream 0,1,0,1,1,0,1,1,1,0 with i_vld=1 -> o_lock=1 one cycle after the third run completes; o_err never asserted.
REQ-032 Locked with exp=5, feed six 1s -> o_err pulse the cycle after the 6th 1; o_lock=0; state HUNT; o_err_cnt=1.
REQ-033 Locked with exp=5, feed 1,1,1,0 -> o_err pulse; state SYNC with ref=3; then runs 4,5 -> relock, o_err_cnt=1.
REQ-034 Lock through runs 254,255,1,2 -> no o_err; o_run_len values 254,255,1,2.
REQ-035 i_vld toggling 50% over the clean stream -> identical o_lock/o_run_len results, stretched in time.
REQ-036 i_reset pulse mid-run while locked -> all outputs 0 asynchronously; relock after three correct runs.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the increasing-run sequence checker: state encoding,
// default widths and the run-length wrap point used by next().
package seq_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int ERR_W_DEF = 16;

  // Longest run in the pattern; the run after it restarts at 1.
  localparam int unsigned RUN_WRAP = 255;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

endpackage

// File: rtl/seq_chk_if.sv
// Bit-stream input and status output bundle of the sequence checker.
// master = stream source / status consumer, slave = checker.
interface seq_chk_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 16
);

  logic             i_vld;
  logic             i_seq;
  logic             i_clr;
  logic             o_lock;
  logic             o_err;
  logic             o_run_vld;
  logic [CNT_W-1:0] o_run_len;
  logic [ERR_W-1:0] o_err_cnt;

  modport master (
    output i_vld, i_seq, i_clr,
    input  o_lock, o_err, o_run_vld, o_run_len, o_err_cnt
  );

  modport slave (
    input  i_vld, i_seq, i_clr,
    output o_lock, o_err, o_run_vld, o_run_len, o_err_cnt
  );

endinterface

// File: rtl/seq_run_meas.sv
// Ones-run measurement: counts 1s, flags run ends and saturation combinationally,
// registers o_run_vld/o_run_len one cycle after the terminating 0; stalls via i_vld.
module seq_run_meas #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vld,
  input  logic             i_seq,
  output logic [CNT_W-1:0] o_run_cnt,
  output logic             o_end_evt,
  output logic             o_ovf,
  output logic             o_run_vld,
  output logic [CNT_W-1:0] o_run_len
);

  logic [CNT_W-1:0] run_cnt_q;
  logic             armed_q;
  logic             run_vld_q;
  logic [CNT_W-1:0] run_len_q;

  // A run only counts once a 0 has been seen before it; reset and
  // saturation both clear that, so the partial/oversized run is discarded.
  assign o_end_evt = i_vld && !i_seq && armed_q;
  assign o_ovf     = i_vld && i_seq && (run_cnt_q == '1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      run_cnt_q <= '0;
      armed_q   <= 1'b0;
      run_vld_q <= 1'b0;
      run_len_q <= '0;
    end else begin
      run_vld_q <= o_end_evt;
      if (o_end_evt) begin
        run_len_q <= run_cnt_q;
      end
      if (i_vld) begin
        if (i_seq) begin
          if (o_ovf) begin
            armed_q <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
        end else begin
          run_cnt_q <= '0;
          armed_q   <= 1'b1;
        end
      end
    end
  end

  assign o_run_cnt = run_cnt_q;
  assign o_run_vld = run_vld_q;
  assign o_run_len = run_len_q;

endmodule

// File: rtl/seq_chk.sv
// Checks a stream of 0-separated 1-runs of length 1,2,..,255,1,.. ; HUNT/SYNC/LOCK FSM.
// Outputs registered one cycle after the sampled bit; no backpressure, stalls via i_vld.
module seq_chk
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic     i_clk,
  input  logic     i_reset,
  seq_chk_if.slave bus
);

  logic [CNT_W-1:0] run_cnt;
  logic             end_evt;
  logic             ovf;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ref_len_q, ref_len_d;
  logic [CNT_W-1:0] exp_len_q, exp_len_d;
  logic             sep_q, sep_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q;

  function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] x);
    return (x == CNT_W'(RUN_WRAP)) ? CNT_W'(1) : x + CNT_W'(1);
  endfunction

  seq_run_meas #(
    .CNT_W(CNT_W)
  ) u_meas (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_vld     (bus.i_vld),
    .i_seq     (bus.i_seq),
    .o_run_cnt (run_cnt),
    .o_end_evt (end_evt),
    .o_ovf     (ovf),
    .o_run_vld (bus.o_run_vld),
    .o_run_len (bus.o_run_len)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= HUNT;
      ref_len_q <= '0;
      exp_len_q <= '0;
      sep_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_len_q <= ref_len_d;
      exp_len_q <= exp_len_d;
      sep_q     <= sep_d;
      err_q     <= err_d;
    end
  end

  // sep_q: in HUNT, one run completion has already been seen and discarded,
  // so the next completed run is trusted as the reference.
  always_comb begin
    state_d   = state_q;
    ref_len_d = ref_len_q;
    exp_len_d = exp_len_q;
    sep_d     = sep_q;
    err_d     = 1'b0;
    if (bus.i_vld) begin
      case (state_q)
        HUNT: begin
          if (ovf) begin
            sep_d = 1'b0;
          end else if (end_evt) begin
            if (sep_q && (run_cnt != '0)) begin
              state_d   = SYNC;
              ref_len_d = run_cnt;
            end else begin
              sep_d = 1'b1;
            end
          end
        end
        SYNC: begin
          if (ovf) begin
            state_d = HUNT;
            sep_d   = 1'b0;
          end else if (end_evt) begin
            if (run_cnt == nxt(ref_len_q)) begin
              state_d   = LOCK;
              exp_len_d = nxt(nxt(ref_len_q));
            end else if (run_cnt == '0) begin
              state_d = HUNT;
              sep_d   = 1'b0;
            end else begin
              ref_len_d = run_cnt;
            end
          end
        end
        LOCK: begin
          if (bus.i_seq) begin
            if ((run_cnt == exp_len_q) || ovf) begin
              err_d   = 1'b1;
              state_d = HUNT;
              sep_d   = 1'b0;
            end
          end else if (run_cnt == exp_len_q) begin
            exp_len_d = nxt(exp_len_q);
          end else begin
            // A 1-run can never exceed exp here, so this is a short run.
            err_d = 1'b1;
            if (run_cnt == '0) begin
              state_d = HUNT;
              sep_d   = 1'b0;
            end else begin
              state_d   = SYNC;
              ref_len_d = run_cnt;
            end
          end
        end
        default: begin
          state_d = HUNT;
          sep_d   = 1'b0;
        end
      endcase
    end
  end

  // Counts the visible o_err pulse, so a clear in that same cycle leaves 1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_cnt_q <= '0;
    end else if (bus.i_clr) begin
      err_cnt_q <= {{(ERR_W-1){1'b0}}, err_q};
    end else if (err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign bus.o_lock    = (state_q == LOCK);
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;

endmodule
